// File: rtl/coin_dispense_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// dispense_pkg
//   Shared definitions for the coin dispense path: the sequencer state
//   encoding, default sizing, and the MMIO register map used by the CPU
//   write decoder and read mux for each of the four denominations.
//   No ports (package).
// -----------------------------------------------------------------------------
package dispense_pkg;

    // Default sizing: 8-bit coin counts, 1 s jam timeout at 30 MHz.
    localparam int DEFAULT_COUNT_W        = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 30_000_000;
    localparam int DEFAULT_TMO_W          = 25;

    // Sequencer states. Exposed on the debug port, so the encoding is fixed.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH    = 3'd1,
        ST_RETRACT = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    // Denomination slots, one sequencer instance each.
    localparam logic [1:0] DENOM_1  = 2'd0;
    localparam logic [1:0] DENOM_5  = 2'd1;
    localparam logic [1:0] DENOM_10 = 2'd2;
    localparam logic [1:0] DENOM_25 = 2'd3;

    // MMIO map: one 16-byte block per denomination, four word registers.
    localparam logic [15:0] MMIO_BASE   = 16'h0400;
    localparam logic [15:0] MMIO_STRIDE = 16'h0010;
    localparam logic [3:0]  REG_CMD     = 4'h0;
    localparam logic [3:0]  REG_COUNT   = 4'h4;
    localparam logic [3:0]  REG_STATUS  = 4'h8;
    localparam logic [3:0]  REG_CLEAR   = 4'hC;

    // Byte address of register reg_off in the block of denomination denom.
    function automatic logic [15:0] mmio_addr(input logic [1:0] denom,
                                              input logic [3:0] reg_off);
        return MMIO_BASE + (MMIO_STRIDE * {14'd0, denom}) + {12'd0, reg_off};
    endfunction

    // Face value in cents of a denomination slot.
    function automatic logic [4:0] denom_value(input logic [1:0] denom);
        logic [4:0] v;
        case (denom)
            DENOM_1:  v = 5'd1;
            DENOM_5:  v = 5'd5;
            DENOM_10: v = 5'd10;
            default:  v = 5'd25;
        endcase
        return v;
    endfunction

    // States that wait on an external event and are guarded by the timeout.
    function automatic logic in_wait_state(input state_e s);
        return (s == ST_PUSH) || (s == ST_RETRACT) || (s == ST_VERIFY);
    endfunction

endpackage

// File: rtl/coin_dispense_sequencer_timeout.sv
// -----------------------------------------------------------------------------
// dispense_timeout
//   Clear/enable cycle counter with a terminal-count flag. Used by the
//   dispense sequencer to detect a servo or beam-break that never arrives.
//   TMO_W must be wide enough to hold TIMEOUT_CYCLES-1.
//
//   clock     in   system clock
//   reset     in   asynchronous active-low reset
//   clear     in   zero the counter (has priority over enable)
//   enable    in   count one cycle
//   terminal  out  counter is enabled and sits at TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module dispense_timeout #(
    parameter int TIMEOUT_CYCLES = 30_000_000,
    parameter int TMO_W          = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [TMO_W-1:0] TERMINAL_COUNT = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != TERMINAL_COUNT)) begin
            // Saturates at the terminal value so it can never wrap.
            count_d = count_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = enable && (count_q == TERMINAL_COUNT);

endmodule

// File: rtl/coin_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// coin_dispense_sequencer
//   Takes a "dispense N coins" command for one denomination, drives the servo
//   through push/retract strokes, confirms each coin on the latched beam-break
//   flag and acknowledges it, and reports progress, completion and jams.
//
//   Handshake: a command is accepted on a cycle where cmd_valid && cmd_ready;
//   cmd_ready is high only in IDLE, cmd_valid at any other time is ignored and
//   nothing is queued.
//
//   clock             in   system clock (30 MHz)
//   reset             in   asynchronous active-low reset
//   cmd_valid         in   command strobe
//   cmd_count         in   coins to dispense
//   cmd_ready         out  idle, command can be accepted
//   clear_error       in   leave ERROR
//   servo_front_done  in   front stroke complete (idles high)
//   servo_back_done   in   back stroke complete (idles high)
//   beam_broken       in   latched beam-break flag, held until beam_ack
//   servo_push        out  1 = front stroke, 0 = rest/back stroke
//   beam_ack          out  one-cycle acknowledge to the beam-break latch
//   busy              out  command in progress
//   done              out  one-cycle completion pulse
//   error             out  jam timeout, held until clear_error
//   dispensed         out  coins confirmed for the current/last command
//   dbg_state         out  current sequencer state
// -----------------------------------------------------------------------------
module coin_dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int COUNT_W        = DEFAULT_COUNT_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TMO_W          = DEFAULT_TMO_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic               cmd_ready,
    input  logic               clear_error,
    input  logic               servo_front_done,
    input  logic               servo_back_done,
    input  logic               beam_broken,
    output logic               servo_push,
    output logic               beam_ack,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] dispensed,
    output state_e             dbg_state
);

    state_e             state_q, state_d;
    logic               front_q, front_d;
    logic               back_q, back_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [COUNT_W-1:0] dispensed_q, dispensed_d;
    logic               servo_push_q, servo_push_d;
    logic               beam_ack_q, beam_ack_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;
    logic               cmd_ready_q, cmd_ready_d;

    logic accept;
    logic front_rise;
    logic back_rise;
    logic last_coin;
    logic tmo_clear;
    logic tmo_enable;
    logic tmo_tc;

    assign accept     = cmd_valid && cmd_ready_q;
    assign front_rise = servo_front_done && !front_q;
    assign back_rise  = servo_back_done && !back_q;
    // remaining is at least 1 whenever VERIFY is reached.
    assign last_coin  = (remaining_q == COUNT_W'(1));
    assign tmo_enable = in_wait_state(state_q);
    assign tmo_clear  = (state_d != state_q);

    dispense_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMO_W          (TMO_W)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (tmo_clear),
        .enable   (tmo_enable),
        .terminal (tmo_tc)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    // The awaited event is tested before the timeout, so an event landing on
    // the terminal-count cycle still advances normally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (cmd_count != '0)) begin
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (front_rise) begin
                    state_d = ST_RETRACT;
                end else if (tmo_tc) begin
                    state_d = ST_ERROR;
                end
            end
            ST_RETRACT: begin
                if (back_rise) begin
                    state_d = ST_VERIFY;
                end else if (tmo_tc) begin
                    state_d = ST_ERROR;
                end
            end
            ST_VERIFY: begin
                if (beam_broken) begin
                    state_d = last_coin ? ST_IDLE : ST_PUSH;
                end else if (tmo_tc) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (clear_error) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Every output is a flop loaded from the next state, so level outputs
    // line up with the state they describe and pulses appear on the edge
    // that makes the transition.
    always_comb begin
        front_d     = servo_front_done;
        back_d      = servo_back_done;
        remaining_d = remaining_q;
        dispensed_d = dispensed_q;
        beam_ack_d  = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    remaining_d = cmd_count;
                    dispensed_d = '0;
                    done_d      = (cmd_count == '0);
                end
            end
            ST_VERIFY: begin
                if (beam_broken) begin
                    beam_ack_d  = 1'b1;
                    dispensed_d = dispensed_q + COUNT_W'(1);
                    remaining_d = remaining_q - COUNT_W'(1);
                    done_d      = last_coin;
                end
            end
            ST_ERROR: begin
                if (clear_error) begin
                    remaining_d = '0;
                end
            end
            default: ;
        endcase

        servo_push_d = (state_d == ST_PUSH);
        busy_d       = in_wait_state(state_d);
        error_d      = (state_d == ST_ERROR);
        cmd_ready_d  = (state_d == ST_IDLE);
    end

    // Done lines idle high, so the edge history resets high to avoid a
    // false rising edge straight out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            front_q      <= 1'b1;
            back_q       <= 1'b1;
            remaining_q  <= '0;
            dispensed_q  <= '0;
            servo_push_q <= 1'b0;
            beam_ack_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            front_q      <= front_d;
            back_q       <= back_d;
            remaining_q  <= remaining_d;
            dispensed_q  <= dispensed_d;
            servo_push_q <= servo_push_d;
            beam_ack_q   <= beam_ack_d;
            done_q       <= done_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign servo_push = servo_push_q;
    assign beam_ack   = beam_ack_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign dispensed  = dispensed_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_coin_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// tb_coin_dispense_sequencer
//   Drives commands into the sequencer with a servo / beam-break environment
//   model. Each command pushes its expected event stream (one ACK per
//   confirmed coin, then DONE, or ERR on a jam) into exp_q; a monitor pops
//   and compares whenever the DUT pulses beam_ack, done or raises error.
// -----------------------------------------------------------------------------
module tb_coin_dispense_sequencer;
    import dispense_pkg::*;

    localparam int COUNT_W = 8;
    localparam int TMO     = 50;
    localparam int TMO_W   = 8;
    localparam int EW      = COUNT_W + 2;
    localparam int EV_ACK  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    // ------------------------------------------------------ clock and reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic               cmd_valid;
    logic [COUNT_W-1:0] cmd_count;
    logic               cmd_ready;
    logic               clear_error;
    logic               servo_front_done;
    logic               servo_back_done;
    logic               beam_broken;
    logic               servo_push;
    logic               beam_ack;
    logic               busy;
    logic               done;
    logic               error;
    logic [COUNT_W-1:0] dispensed;
    state_e             dbg_state;

    coin_dispense_sequencer #(
        .COUNT_W        (COUNT_W),
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (TMO_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_count        (cmd_count),
        .cmd_ready        (cmd_ready),
        .clear_error      (clear_error),
        .servo_front_done (servo_front_done),
        .servo_back_done  (servo_back_done),
        .beam_broken      (beam_broken),
        .servo_push       (servo_push),
        .beam_ack         (beam_ack),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .dispensed        (dispensed),
        .dbg_state        (dbg_state)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    logic [EW-1:0] exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // ------------------------------------------------------------- checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [EW-1:0] ev(input int kind, input int val);
        logic [1:0]         k;
        logic [COUNT_W-1:0] v;
        k = kind[1:0];
        v = val[COUNT_W-1:0];
        return {k, v};
    endfunction

    task automatic sb_pop(input string name, input logic [EW-1:0] got);
        logic [EW-1:0] exp;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: unexpected event kind=%0d dispensed=%0d, expected no event",
                     name, got[EW-1:COUNT_W], got[COUNT_W-1:0]);
        end else begin
            exp = exp_q.pop_front();
            check(name, got, exp);
        end
    endtask

    // Reference model: coins 1..n are each confirmed, then completion. A jam
    // while handling coin index fail_at (0-based) stops after fail_at coins.
    task automatic expect_cmd(input int n, input int fail_at);
        if (fail_at >= 0) begin
            for (int k = 1; k <= fail_at; k++) exp_q.push_back(ev(EV_ACK, k));
            exp_q.push_back(ev(EV_ERR, fail_at));
        end else begin
            for (int k = 1; k <= n; k++) exp_q.push_back(ev(EV_ACK, k));
            exp_q.push_back(ev(EV_DONE, n));
        end
    endtask

    // --------------------------------------------------------------- monitor
    logic ack_prev    = 1'b0;
    logic done_prev   = 1'b0;
    logic err_prev    = 1'b0;
    logic push_prev_m = 1'b0;
    int   push_rises    = 0;
    int   last_ack_cyc  = 0;
    int   last_done_cyc = 0;

    always @(negedge clock) begin
        if (!reset) begin
            ack_prev    <= 1'b0;
            done_prev   <= 1'b0;
            err_prev    <= 1'b0;
            push_prev_m <= 1'b0;
        end else begin
            if (beam_ack) begin
                sb_pop("beam_ack_event", ev(EV_ACK, int'(dispensed)));
                check("beam_ack_single", ack_prev, 1'b0);
                last_ack_cyc <= cyc;
            end
            if (done) begin
                sb_pop("done_event", ev(EV_DONE, int'(dispensed)));
                check("done_single", done_prev, 1'b0);
                check("done_ready", cmd_ready, 1'b1);
                last_done_cyc <= cyc;
            end
            if (error && !err_prev) sb_pop("error_event", ev(EV_ERR, int'(dispensed)));
            if (error) begin
                check("error_push_low", servo_push, 1'b0);
                check("error_not_busy", busy, 1'b0);
            end
            if (servo_push && !push_prev_m) push_rises <= push_rises + 1;
            ack_prev    <= beam_ack;
            done_prev   <= done;
            err_prev    <= error;
            push_prev_m <= servo_push;
        end
    end

    // ------------------------------------------------- servo / beam model
    int front_dly = 10;
    int back_dly  = 10;
    int beam_dly  = 5;      // 0: beam never breaks
    bit beam_pre  = 1'b0;   // beam latched during PUSH, before VERIFY
    int back_rise_cyc = 0;
    int push_fall_cyc = 0;

    initial begin
        int  f_cnt;
        int  b_cnt;
        int  m_cnt;
        logic push_prev;
        f_cnt = 0; b_cnt = 0; m_cnt = 0; push_prev = 1'b0;
        servo_front_done = 1'b1;
        servo_back_done  = 1'b1;
        beam_broken      = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                f_cnt = 0; b_cnt = 0; m_cnt = 0; push_prev = 1'b0;
                servo_front_done = 1'b1;
                servo_back_done  = 1'b1;
                beam_broken      = 1'b0;
            end else begin
                if (beam_ack) beam_broken = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) beam_broken = 1'b1;
                end
                if (servo_push && !push_prev) begin
                    servo_front_done = 1'b0;
                    f_cnt = front_dly;
                end else if (f_cnt > 0) begin
                    f_cnt--;
                    if (f_cnt == 0) begin
                        servo_front_done = 1'b1;
                        if (beam_pre) beam_broken = 1'b1;
                    end
                end
                if (!servo_push && push_prev) begin
                    servo_back_done = 1'b0;
                    b_cnt = back_dly;
                    push_fall_cyc = cyc;
                end else if (b_cnt > 0) begin
                    b_cnt--;
                    if (b_cnt == 0) begin
                        servo_back_done = 1'b1;
                        back_rise_cyc = cyc;
                        if (!beam_pre && beam_dly > 0) m_cnt = beam_dly;
                    end
                end
                push_prev = servo_push;
            end
        end
    end

    // -------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input int n);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 1000) begin
            tick();
            guard++;
        end
        check("ready_before_issue", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_count = COUNT_W'(n);
        tick();
        cmd_valid = 1'b0;
        cmd_count = COUNT_W'($urandom_range(0, 255));
        check("accept_push", servo_push, (n != 0));
        check("accept_busy", busy, (n != 0));
        check("accept_ready", cmd_ready, (n == 0));
        check("accept_done", done, (n == 0));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 3000) begin
            tick();
            guard++;
        end
        check("idle_within_budget", busy, 1'b0);
    endtask

    task automatic wait_error(output int at_cyc);
        int guard;
        guard = 0;
        while (!error && guard < 500) begin
            tick();
            guard++;
        end
        check("error_within_budget", error, 1'b1);
        at_cyc = cyc;
    endtask

    task automatic finish_cmd(input int n);
        wait_idle();
        tick();
        check("dispensed_final", dispensed, n);
        check("idle_ready", cmd_ready, 1'b1);
        if (n > 0) begin
            check("ack_latency", last_ack_cyc - back_rise_cyc, beam_pre ? 2 : beam_dly + 1);
            check("done_with_last_ack", last_done_cyc, last_ack_cyc);
        end
    endtask

    task automatic clear_jam();
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("clear_error_low", error, 1'b0);
        check("clear_ready", cmd_ready, 1'b1);
        check("clear_state", dbg_state, ST_IDLE);
        repeat (3) tick();
        check("clear_no_done", last_done_cyc < cyc - 3, 1'b1);
    endtask

    task automatic env_normal();
        front_dly = 10;
        back_dly  = 10;
        beam_dly  = 5;
        beam_pre  = 1'b0;
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        int base;
        int ecyc;
        int n;
        cmd_valid   = 1'b0;
        cmd_count   = '0;
        clear_error = 1'b0;
        env_normal();

        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_push", servo_push, 1'b0);
        check("rst_ack", beam_ack, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_dispensed", dispensed, 0);
        check("rst_state", dbg_state, ST_IDLE);
        reset = 1'b1;
        tick();

        // Three coins, beam 5 cycles into each VERIFY.
        base = push_rises;
        expect_cmd(3, -1);
        issue(3);
        finish_cmd(3);
        check("three_push_strokes", push_rises - base, 3);

        // Zero-coin command completes without moving the servo.
        base = push_rises;
        expect_cmd(0, -1);
        issue(0);
        finish_cmd(0);
        repeat (2) tick();
        check("zero_no_push", push_rises - base, 0);

        // Beam never breaks: jam after the 50th VERIFY cycle.
        beam_dly = 0;
        expect_cmd(2, 0);
        issue(2);
        wait_error(ecyc);
        check("verify_timeout_cycle", ecyc - back_rise_cyc, TMO + 1);
        check("jam_dispensed", dispensed, 0);
        check("jam_state", dbg_state, ST_ERROR);
        clear_jam();
        env_normal();

        // Beam already latched before VERIFY.
        beam_pre = 1'b1;
        expect_cmd(1, -1);
        issue(1);
        finish_cmd(1);
        env_normal();

        // Reset during the second PUSH of a five-coin command.
        expect_cmd(5, -1);
        issue(5);
        begin
            int guard;
            guard = 0;
            while (dispensed != 1 && guard < 500) begin
                tick();
                guard++;
            end
        end
        check("reset_test_first_coin", dispensed, 1);
        tick();
        tick();
        check("reset_test_in_push", servo_push, 1'b1);
        #3 reset = 1'b0;
        #2;
        check("async_rst_push", servo_push, 1'b0);
        check("async_rst_dispensed", dispensed, 0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ready", cmd_ready, 1'b1);
        check("events_left_at_reset", exp_q.size(), 5);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_ready", cmd_ready, 1'b1);
        check("post_rst_state", dbg_state, ST_IDLE);

        // Second command and a clear_error while busy are both ignored.
        expect_cmd(2, -1);
        issue(2);
        tick();
        cmd_valid   = 1'b1;
        cmd_count   = 8'd7;
        clear_error = 1'b1;
        tick();
        cmd_valid   = 1'b0;
        clear_error = 1'b0;
        check("busy_ignores_cmd", busy, 1'b1);
        finish_cmd(2);

        // Back edge on the terminal-count cycle wins over the timeout.
        back_dly = TMO - 1;
        expect_cmd(1, -1);
        issue(1);
        finish_cmd(1);

        // One cycle later it is a jam in RETRACT.
        back_dly = TMO;
        beam_dly = 0;
        expect_cmd(1, 0);
        issue(1);
        wait_error(ecyc);
        check("retract_timeout_cycle", ecyc - push_fall_cyc, TMO);
        clear_jam();
        env_normal();

        // Randomized commands and environment timing.
        for (int i = 0; i < 12; i++) begin
            n         = $urandom_range(0, 4);
            front_dly = $urandom_range(1, 12);
            back_dly  = $urandom_range(1, 12);
            beam_dly  = $urandom_range(1, 8);
            beam_pre  = ($urandom_range(0, 3) == 0);
            expect_cmd(n, -1);
            issue(n);
            if (n > 0 && $urandom_range(0, 1) == 1) begin
                cmd_valid = 1'b1;
                cmd_count = COUNT_W'($urandom_range(1, 255));
                tick();
                cmd_valid = 1'b0;
            end
            finish_cmd(n);
        end

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
        $fatal(1, "watchdog expired");
    end

endmodule
